program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Upstream feeder for the 4-register 8-bit processor.
- Holds a small loadable program memory and drives the processor's DIN and Run inputs.
- Issues one instruction word per processor Done. For mvi it presents the immediate word in the following cycle.
- Stops at an end marker or an illegal opcode and reports completion.

Parameters:
ADDR_W, 4, program address width; DEPTH = 2**ADDR_W words (16)

Ports:
Clk  input  1  system clock, all state on rising edge
Resetn  input  1  asynchronous active-low reset
LoadEn  input  1  write LoadData to memory at LoadAddr (accepted only when Busy=0)
LoadAddr  input  ADDR_W  program memory write address
LoadData  input  8  program word
Start  input  1  begin execution from address 0 (accepted only when Busy=0)
Done  input  1  processor Done, combinational from the processor
DIN  output  8  word to processor DIN
Run  output  1  processor Run
Busy  output  1  high while not IDLE
PC  output  ADDR_W  current read address
ProgDone  output  1  one-cycle pulse when execution stops
Error  output  1  stopped on illegal opcode; sticky until next accepted Start
InstrCount  output  8  instructions issued since Start, saturates at 255

Behaviour:
- Word format: bit7 = END, bits[6:4] = opcode (000 mv, 001 mvi, 010 add, 011 sub), bits[3:2] = X, bits[1:0] = Y.
- Opcode bit6 = 1 is illegal.
- Reset: state IDLE, PC=0, ProgDone=0, Error=0, InstrCount=0. All memory words = 8'h80 (END), so an unloaded program halts at once.
- DIN = mem[PC] (asynchronous read) in every state.
- Run and Busy are combinational from state.
- States: IDLE, ISSUE, WAIT.
- IDLE: Run=0, Busy=0.
  - LoadEn writes mem[LoadAddr] at the clock edge.
  - Start moves to ISSUE; PC<=0, InstrCount<=0, Error<=0.
  - Start and LoadEn in the same cycle: both take effect. The written word is visible in ISSUE.
- ISSUE (processor in T0): examine the word at mem[PC].
  - END=1: Run=0, go IDLE, ProgDone=1 next cycle.
  - Illegal opcode: Run=0, go IDLE, Error<=1, ProgDone=1 next cycle.
  - Otherwise: Run=1, InstrCount++ (saturating), go WAIT.
  - If opcode is mvi, also PC<=PC+1 so DIN carries the immediate during processor T1.
- WAIT: Run=0. When Done=1: PC<=PC+1, go ISSUE. When Done=0: hold.
- Processor latency seen by WAIT: mv and mvi give Done in the 1st WAIT cycle; add and sub give Done in the 3rd WAIT cycle.
- Back-to-back: an instruction is issued in the cycle right after Done, when the processor is back in T0.
- PC wraps modulo DEPTH, including an mvi at the last address, whose immediate comes from address 0.
- Ignored inputs:
  - LoadEn and Start while Busy=1.
  - Done while in IDLE or ISSUE.
- ProgDone is registered: high exactly one cycle, the first IDLE cycle after the stop.
- Reset mid-program returns immediately to reset values. Memory contents revert to 8'h80.

Decomposition:
- Shared package:
  - opcode constants MV/MVI/ADD/SUB
  - END_BIT = 7
  - ILLEGAL_BIT = 6
  - state encoding IDLE/ISSUE/WAIT (2 bits)
- Sub-module prog_mem: DEPTH x 8 register file.
  - One synchronous write port, one asynchronous read port.
  - Async reset fills every word with 8'h80.

Test Plan:
- Reset with no load, then Start -> Run never high; ProgDone pulses 2 cycles after Start edge; InstrCount=0; Error=0.
- Load 0x14,0x05,0x18,0x03,0x26,0x80 with the processor attached, then Start.
  - Processor: R1=8'h08, R2=8'h03.
  - Run high in cycles 1, 3, 5 after Start.
  - ProgDone in cycle 10; InstrCount=3; PC=5.
- Load 0x14,0x0A,0x34,0x80 (mvi R1,#10; sub R1,R0) -> R1=8'h0A; DIN=8'h0A during the processor T1 of mvi; ProgDone with Error=0.
- Load 0x40 at address 0 -> Run stays 0; Error=1; ProgDone pulse; the next Start clears Error.
- Fill all 16 words with 0x01 (mv R0,R1), no END -> PC wraps 15->0; InstrCount saturates at 255 and holds; Busy stays 1.
- Pulse Resetn low in a WAIT cycle of an add, and pulse LoadEn/Start while Busy -> all outputs return to reset values immediately; the writes made while Busy are not present; mem[0] reads 8'h80.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// program_sequencer_pkg
// Shared definitions for the program sequencer that feeds the 4-register
// 8-bit processor: the program word layout, the opcode values, the sequencer
// state encoding and small helpers that decode a program word.
//
// Program word layout:
//   bit 7    END marker (stop before issuing this word)
//   bit 6    illegal-opcode flag (any word with bit 6 set is illegal)
//   [6:4]    opcode (MV, MVI, ADD, SUB)
//   [3:2]    destination register X
//   [1:0]    source register Y
// -----------------------------------------------------------------------------
package program_sequencer_pkg;

   localparam int unsigned WORD_W      = 8;
   localparam int unsigned END_BIT     = 7;
   localparam int unsigned ILLEGAL_BIT = 6;

   // An erased program word is an END marker, so an unloaded program halts at once.
   localparam logic [WORD_W-1:0] END_WORD = 8'h80;

   localparam logic [2:0] MV  = 3'b000;
   localparam logic [2:0] MVI = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] SUB = 3'b011;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } state_e;

   function automatic logic word_is_end(input logic [WORD_W-1:0] word);
      return word[END_BIT];
   endfunction

   function automatic logic word_is_illegal(input logic [WORD_W-1:0] word);
      return word[ILLEGAL_BIT];
   endfunction

   function automatic logic [2:0] word_opcode(input logic [WORD_W-1:0] word);
      return word[6:4];
   endfunction

   // Instruction counter that sticks at its maximum instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = 8'hFF;
      end else begin
         result = value + 8'h01;
      end
      return result;
   endfunction

endpackage

// File: rtl/program_sequencer_prog_mem.sv
// -----------------------------------------------------------------------------
// prog_mem
// DEPTH x 8 program register file with one synchronous write port and one
// asynchronous read port. Reset fills every word with the END marker.
//
// Ports:
//   clk_i    system clock, writes on the rising edge
//   rst_ni   asynchronous active-low reset (all words <= END_WORD)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module prog_mem
   import program_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WORD_W-1:0] mem_q [DEPTH];

   // Storage array: erased to END on reset, single write port otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= END_WORD;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Upstream feeder for the 4-register 8-bit processor. Holds a loadable
// program and issues one instruction per processor Done. For MVI the PC is
// advanced at issue so DIN carries the immediate during processor T1.
// Execution stops at an END word or an illegal opcode.
//
// Ports:
//   Clk         system clock
//   Resetn      asynchronous active-low reset
//   LoadEn      write LoadData to LoadAddr (only while idle)
//   LoadAddr    program write address
//   LoadData    program word
//   Start       begin execution at address 0 (only while idle)
//   Done        processor Done (combinational from the processor)
//   DIN         program word at PC, to processor DIN
//   Run         processor Run
//   Busy        high while not idle
//   PC          current read address
//   ProgDone    one-cycle pulse in the first idle cycle after a stop
//   Error       stopped on an illegal opcode; cleared by the next Start
//   InstrCount  instructions issued since Start, saturating at 255
// -----------------------------------------------------------------------------
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              Clk,
   input  logic              Resetn,
   input  logic              LoadEn,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [WORD_W-1:0] LoadData,
   input  logic              Start,
   input  logic              Done,
   output logic [WORD_W-1:0] DIN,
   output logic              Run,
   output logic              Busy,
   output logic [ADDR_W-1:0] PC,
   output logic              ProgDone,
   output logic              Error,
   output logic [7:0]        InstrCount
);

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              pdone_q, pdone_d;

   logic [WORD_W-1:0] word_s;
   logic              stop_s;
   logic              illegal_s;
   logic              mem_we_s;
   logic              run_s;
   logic              busy_s;

   // Loads are accepted only while idle; writes during execution are dropped.
   assign mem_we_s = LoadEn && (state_q == IDLE);

   prog_mem #(
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk_i   (Clk),
      .rst_ni  (Resetn),
      .we_i    (mem_we_s),
      .waddr_i (LoadAddr),
      .wdata_i (LoadData),
      .raddr_i (pc_q),
      .rdata_o (word_s)
   );

   // END takes precedence over the illegal flag: an END word never raises Error.
   assign illegal_s = !word_is_end(word_s) && word_is_illegal(word_s);
   assign stop_s    = word_is_end(word_s) || word_is_illegal(word_s);

   // FSM state register.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; Done is only meaningful while waiting.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (stop_s) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (Done) begin
               state_d = ISSUE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: Run only when a legal, non-END word is presented in ISSUE.
   always_comb begin
      run_s  = 1'b0;
      busy_s = 1'b0;
      case (state_q)
         IDLE: begin
            run_s  = 1'b0;
            busy_s = 1'b0;
         end
         ISSUE: begin
            run_s  = !stop_s;
            busy_s = 1'b1;
         end
         WAIT: begin
            run_s  = 1'b0;
            busy_s = 1'b1;
         end
         default: begin
            run_s  = 1'b0;
            busy_s = 1'b0;
         end
      endcase
   end

   // Datapath next values: PC, instruction counter, Error and the stop pulse.
   always_comb begin
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      pdone_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               pc_d  = {ADDR_W{1'b0}};
               cnt_d = 8'h00;
               err_d = 1'b0;
            end else begin
               pc_d  = pc_q;
               cnt_d = cnt_q;
               err_d = err_q;
            end
         end
         ISSUE: begin
            if (stop_s) begin
               pdone_d = 1'b1;
               err_d   = illegal_s;
            end else begin
               cnt_d = sat_inc8(cnt_q);
               // Step onto the immediate so the processor sees it in T1.
               if (word_opcode(word_s) == MVI) begin
                  pc_d = pc_q + PC_ONE;
               end else begin
                  pc_d = pc_q;
               end
            end
         end
         WAIT: begin
            if (Done) begin
               pc_d = pc_q + PC_ONE;
            end else begin
               pc_d = pc_q;
            end
         end
         default: begin
            pc_d    = pc_q;
            pdone_d = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         pc_q    <= {ADDR_W{1'b0}};
         cnt_q   <= 8'h00;
         err_q   <= 1'b0;
         pdone_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         pdone_q <= pdone_d;
      end
   end

   assign DIN        = word_s;
   assign Run        = run_s;
   assign Busy       = busy_s;
   assign PC         = pc_q;
   assign ProgDone   = pdone_q;
   assign Error      = err_q;
   assign InstrCount = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
// Drives program_sequencer with a small processor model attached, and checks
// every cycle against an instruction-level reference: on Start the reference
// walks the program and expands each instruction into its expected cycles
// (issue cycle plus the fixed processor latency), queued ahead of time.
// -----------------------------------------------------------------------------
module tb_program_sequencer;

   logic       Clk = 1'b0;
   logic       Resetn;
   logic       LoadEn;
   logic [3:0] LoadAddr;
   logic [7:0] LoadData;
   logic       Start;
   logic       Done;
   logic [7:0] DIN;
   logic       Run;
   logic       Busy;
   logic [3:0] PC;
   logic       ProgDone;
   logic       Error;
   logic [7:0] InstrCount;

   program_sequencer #(.ADDR_W(4)) dut (
      .Clk        (Clk),
      .Resetn     (Resetn),
      .LoadEn     (LoadEn),
      .LoadAddr   (LoadAddr),
      .LoadData   (LoadData),
      .Start      (Start),
      .Done       (Done),
      .DIN        (DIN),
      .Run        (Run),
      .Busy       (Busy),
      .PC         (PC),
      .ProgDone   (ProgDone),
      .Error      (Error),
      .InstrCount (InstrCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit       run;
      bit       busy;
      bit [3:0] pc;
      bit       pd;
      bit       err;
      bit [7:0] cnt;
   } exp_t;

   // Reference model state
   bit [7:0] mem_m [16];
   exp_t     exp_q [$];
   exp_t     cur;
   bit       gen_active;
   bit [3:0] gen_pc;
   bit [7:0] gen_cnt;
   bit [3:0] fin_pc;
   bit [7:0] fin_cnt;
   bit       fin_err;

   // Processor model state
   bit       p_act;
   bit [2:0] p_op;
   bit [1:0] p_x, p_y;
   int       p_step;
   bit [7:0] R [4];
   bit [7:0] acc_a, acc_g;
   bit [7:0] last_imm;
   bit       stray_en;
   bit       noise_en;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   int cyc_since;
   bit [31:0] run_mask;
   int pd_at;

   function automatic exp_t idle_exp(input bit pd);
      exp_t e;
      e.run = 1'b0; e.busy = 1'b0; e.pc = fin_pc; e.pd = pd;
      e.err = fin_err; e.cnt = fin_cnt;
      return e;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) mem_m[i] = 8'h80;
      exp_q.delete();
      gen_active = 1'b0;
      fin_pc = 4'd0; fin_cnt = 8'd0; fin_err = 1'b0;
      cur = idle_exp(1'b0);
   endfunction

   // Expand the instruction at gen_pc into its expected cycles.
   function automatic void expand_one();
      bit [7:0] w;
      exp_t     e;
      bit [3:0] p2;
      bit [7:0] c2;
      int       lat;
      w = mem_m[gen_pc];
      e.busy = 1'b1; e.pd = 1'b0; e.err = 1'b0; e.cnt = gen_cnt; e.pc = gen_pc;
      if (w[7] || w[6]) begin
         e.run = 1'b0;
         exp_q.push_back(e);
         fin_pc = gen_pc; fin_cnt = gen_cnt; fin_err = !w[7];
         exp_q.push_back(idle_exp(1'b1));
         gen_active = 1'b0;
      end else begin
         e.run = 1'b1;
         exp_q.push_back(e);
         c2  = (gen_cnt == 8'd255) ? 8'd255 : 8'(gen_cnt + 8'd1);
         p2  = (w[6:4] == 3'b001) ? 4'(gen_pc + 4'd1) : gen_pc;
         lat = w[5] ? 3 : 1;
         for (int k = 0; k < lat; k++) begin
            e.run = 1'b0; e.pc = p2; e.cnt = c2;
            exp_q.push_back(e);
         end
         gen_pc  = 4'(p2 + 4'd1);
         gen_cnt = c2;
      end
   endfunction

   function automatic void model_edge(input bit le, input bit [3:0] la,
                                      input bit [7:0] ld, input bit st);
      if (!cur.busy) begin
         if (le) mem_m[la] = ld;
         if (st) begin
            gen_active = 1'b1; gen_pc = 4'd0; gen_cnt = 8'd0;
         end
      end
      while (gen_active && exp_q.size() < 8) expand_one();
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = idle_exp(1'b0);
   endfunction

   function automatic void proc_reset();
      p_act = 1'b0; p_step = 0;
      for (int i = 0; i < 4; i++) R[i] = 8'h00;
   endfunction

   function automatic bit proc_done();
      return p_act && ((!p_op[1] && p_step == 1) || (p_op[1] && p_step == 3));
   endfunction

   function automatic void proc_edge(input bit run_s, input bit [7:0] din_s);
      bit d;
      if (p_act) begin
         d = proc_done();
         if (p_op == 3'd1 && p_step == 1) begin R[p_x] = din_s; last_imm = din_s; end
         else if (p_op == 3'd0 && p_step == 1) R[p_x] = R[p_y];
         else if (p_op[1] && p_step == 1) acc_a = R[p_x];
         else if (p_op[1] && p_step == 2) acc_g = p_op[0] ? 8'(acc_a - R[p_y]) : 8'(acc_a + R[p_y]);
         else if (p_op[1] && p_step == 3) R[p_x] = acc_g;
         if (d) p_act = 1'b0;
         else p_step = p_step + 1;
      end else if (run_s) begin
         p_act = 1'b1; p_op = din_s[6:4]; p_x = din_s[3:2]; p_y = din_s[1:0]; p_step = 1;
      end
   endfunction

   task automatic check(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // One clock: model and processor follow the edge, then Done is driven.
   task automatic cycle();
      bit       run_s, le, st;
      bit [7:0] din_s, ld;
      bit [3:0] la;
      int       r;
      run_s = Run; din_s = DIN; le = LoadEn; st = Start; la = LoadAddr; ld = LoadData;
      @(posedge Clk);
      if (!Resetn) begin
         model_reset(); proc_reset();
      end else begin
         model_edge(le, la, ld, st);
         proc_edge(run_s, din_s);
      end
      #1;
      r = $urandom_range(0, 3);
      Done = Resetn && (proc_done() || (stray_en && !p_act && r == 0));
      cyc_since++;
      if (cyc_since < 32 && Run) run_mask[cyc_since] = 1'b1;
      if (ProgDone) pd_at = cyc_since;
   endtask

   // Per-cycle comparison against the reference model.
   always @(negedge Clk) begin
      if (chk_en) begin
         n_cmp++;
         if (Run !== cur.run || Busy !== cur.busy || PC !== cur.pc || ProgDone !== cur.pd ||
             Error !== cur.err || InstrCount !== cur.cnt || DIN !== mem_m[cur.pc]) begin
            n_err++;
            $display("FAIL cycle t=%0t: got run=%b busy=%b pc=%0d pd=%b err=%b cnt=%0d din=%h, expected run=%b busy=%b pc=%0d pd=%b err=%b cnt=%0d din=%h",
                     $time, Run, Busy, PC, ProgDone, Error, InstrCount, DIN,
                     cur.run, cur.busy, cur.pc, cur.pd, cur.err, cur.cnt, mem_m[cur.pc]);
         end
      end
   end

   task automatic load(input bit [3:0] a, input bit [7:0] d);
      LoadEn = 1'b1; LoadAddr = a; LoadData = d;
      cycle();
      LoadEn = 1'b0;
   endtask

   task automatic start_prog();
      Start = 1'b1; run_mask = 32'd0; pd_at = -1; cyc_since = 0;
      cycle();
      Start = 1'b0;
   endtask

   task automatic run_to_idle(input int bound);
      bit   ok;
      bit [31:0] r;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (noise_en) begin
            r = $urandom;
            LoadEn = (r[1:0] == 2'd0); Start = (r[3:2] == 2'd0);
            LoadAddr = r[7:4]; LoadData = r[15:8];
         end
         cycle();
         if (!Busy && !cur.busy) begin ok = 1'b1; break; end
      end
      LoadEn = 1'b0; Start = 1'b0;
      if (!ok) check("idle_timeout", 0, 1);
   endtask

   task automatic do_reset();
      Resetn = 1'b0; LoadEn = 1'b0; Start = 1'b0; Done = 1'b0;
      model_reset(); proc_reset();
      #1;
      check("rst_busy", int'(Busy), 0);
      check("rst_run", int'(Run), 0);
      check("rst_pc", int'(PC), 0);
      check("rst_pdone", int'(ProgDone), 0);
      check("rst_err", int'(Error), 0);
      check("rst_cnt", int'(InstrCount), 0);
      check("rst_mem0", int'(DIN), 8'h80);
      cycle();
      Resetn = 1'b1;
      cycle();
   endtask

   initial begin
      bit [7:0]  prog [16];
      bit [31:0] r;
      int        pos, len;
      Resetn = 1'b1; LoadEn = 1'b0; LoadAddr = 4'd0; LoadData = 8'd0;
      Start = 1'b0; Done = 1'b0; stray_en = 1'b0; noise_en = 1'b0;
      last_imm = 8'd0; cyc_since = 0; run_mask = 32'd0; pd_at = -1;
      #1;
      do_reset();
      chk_en = 1'b1;
      stray_en = 1'b1;

      // Unloaded program halts immediately
      start_prog();
      run_to_idle(20);
      check("empty_run", int'(run_mask), 0);
      check("empty_pd_cycle", pd_at, 2);
      check("empty_cnt", int'(InstrCount), 0);
      check("empty_err", int'(Error), 0);

      // mvi R1,#5; mvi R2,#3; add R1,R2; END
      load(4'd0, 8'h14); load(4'd1, 8'h05); load(4'd2, 8'h18);
      load(4'd3, 8'h03); load(4'd4, 8'h26); load(4'd5, 8'h80);
      start_prog();
      run_to_idle(40);
      check("p1_run_cycles", int'(run_mask), 32'h2A);
      check("p1_pd_cycle", pd_at, 10);
      check("p1_cnt", int'(InstrCount), 3);
      check("p1_pc", int'(PC), 5);
      check("p1_r1", int'(R[1]), 8'h08);
      check("p1_r2", int'(R[2]), 8'h03);

      // mvi R1,#10; sub R1,R0; END
      load(4'd0, 8'h14); load(4'd1, 8'h0A); load(4'd2, 8'h34); load(4'd3, 8'h80);
      start_prog();
      run_to_idle(40);
      check("p2_imm", int'(last_imm), 8'h0A);
      check("p2_r1", int'(R[1]), 8'h0A);
      check("p2_err", int'(Error), 0);
      check("p2_pd_cycle", pd_at, 8);

      // Illegal opcode at address 0
      load(4'd0, 8'h40);
      start_prog();
      run_to_idle(20);
      check("ill_err", int'(Error), 1);
      check("ill_run", int'(run_mask), 0);
      check("ill_pd_cycle", pd_at, 2);
      start_prog();
      check("ill_err_cleared", int'(Error), 0);
      run_to_idle(20);

      // Endless mv loop: PC wraps and the counter saturates
      for (int i = 0; i < 16; i++) load(4'(i), 8'h01);
      start_prog();
      repeat (600) cycle();
      check("sat_cnt", int'(InstrCount), 255);
      check("sat_busy", int'(Busy), 1);
      do_reset();

      // add R1,R2 with a load/start attempt while busy
      load(4'd0, 8'h26);
      start_prog();
      cycle();
      LoadEn = 1'b1; LoadAddr = 4'd1; LoadData = 8'h05; Start = 1'b1;
      cycle();
      LoadEn = 1'b0; Start = 1'b0;
      run_to_idle(20);
      check("busy_write_dropped", int'(DIN), 8'h80);
      check("busy_pc", int'(PC), 1);
      start_prog();
      cycle();
      cycle();
      do_reset();

      // Randomized programs that always reach a stop word
      noise_en = 1'b1;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < 16; i++) begin r = $urandom; prog[i] = r[7:0]; end
         len = $urandom_range(0, 11);
         pos = 0;
         while (pos < len && pos < 14) begin
            r = $urandom;
            prog[pos] = {2'b00, r[5:0]};
            pos++;
            if (r[5:4] == 2'b01) pos++;
         end
         r = $urandom;
         prog[pos] = (r[9:8] == 2'b00) ? {2'b01, r[5:0]} : {1'b1, r[6:0]};
         for (int i = 0; i < 16; i++) load(4'(i), prog[i]);
         start_prog();
         run_to_idle(200);
      end
      noise_en = 1'b0;
      repeat (3) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
